// File: rtl/irq_ctrl_vec.sv
// irq_ctrl_vec: vectored interrupt controller with edge-latched pending bits, writable mask,
// fixed priority (lowest index wins) and an active-handler stack for nested preemption.
// Ports: clk/res (async active-low reset), irq_src (raw sources), mask_we/mask_wdata (mask write),
// irq_ack/irq_ack_id (core accept), irq_ret (mret pulse), irq/irq_id/irq_adr (request + vector),
// mask, pending, nest_lvl (active handlers), ack_err (mismatched ack pulse).
// Macro IRQ_NEST_EN: defined enables nesting up to NEST_DEPTH; undefined uses a single active flag.
module irq_ctrl_vec #(
  parameter int NUM_IRQ = 32,
  parameter int ID_W = 5,
  parameter logic [31:0] VEC_BASE = 32'h1C00_8000,
  parameter int NEST_DEPTH = 4,
  localparam int LW = $clog2(NEST_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               res,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               irq_ack,
  input  logic [ID_W-1:0]    irq_ack_id,
  input  logic               irq_ret,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id,
  output logic [31:0]        irq_adr,
  output logic [NUM_IRQ-1:0] mask,
  output logic [NUM_IRQ-1:0] pending,
  output logic [LW-1:0]      nest_lvl,
  output logic               ack_err
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state, state_n;
  logic [NUM_IRQ-1:0] src_q, rise, elig, id_oh;
  logic [ID_W-1:0] cand, id_n;
  logic cand_v, go, live, ack_ok, pop;
  assign rise = irq_src & ~src_q;
  assign elig = pending & mask;
  assign cand_v = |elig;
  assign id_oh = NUM_IRQ'(1) << irq_id;
  // the latched request stays alive only while its source is both pending and enabled
  assign live = |(elig & id_oh);
  assign ack_ok = irq_ack && state == REQ && irq_ack_id == irq_id;
  assign pop = irq_ret && nest_lvl != '0;
  always_comb begin
    cand = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--)
      if (elig[k]) cand = ID_W'(k);
  end
`ifdef IRQ_NEST_EN
  logic [ID_W-1:0] stk [NEST_DEPTH];
  logic [ID_W-1:0] top;
  logic [LW-1:0] base;
  // a return and an ack in the same cycle pop first, so the push lands on the freed slot
  assign base = nest_lvl - LW'(pop);
  always_comb begin
    top = '0;
    for (int k = 0; k < NEST_DEPTH; k++)
      if (nest_lvl == LW'(k + 1)) top = stk[k];
  end
  assign go = cand_v && (nest_lvl == '0 || (cand < top && nest_lvl < LW'(NEST_DEPTH)));
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      nest_lvl <= '0;
      for (int k = 0; k < NEST_DEPTH; k++) stk[k] <= '0;
    end else begin
      nest_lvl <= base + LW'(ack_ok);
      for (int k = 0; k < NEST_DEPTH; k++)
        if (ack_ok && base == LW'(k)) stk[k] <= irq_id;
    end
  end
`else
  assign go = cand_v && nest_lvl == '0;
  always_ff @(posedge clk or negedge res) begin
    if (!res) nest_lvl <= '0;
    else nest_lvl <= ack_ok ? LW'(1) : pop ? '0 : nest_lvl;
  end
`endif
  always_comb begin
    state_n = state == IDLE ? (go ? REQ : IDLE) : (ack_ok || !live ? IDLE : REQ);
    id_n = state == IDLE && go ? cand : irq_id;
  end
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= IDLE;
      src_q <= '0;
      pending <= '0;
      mask <= '0;
      irq <= 1'b0;
      irq_id <= '0;
      irq_adr <= VEC_BASE;
      ack_err <= 1'b0;
    end else begin
      state <= state_n;
      src_q <= irq_src;
      // a fresh edge on the acknowledged source wins over the clear
      pending <= (pending & ~(id_oh & {NUM_IRQ{ack_ok}})) | rise;
      mask <= mask_we ? mask_wdata : mask;
      irq <= state_n == REQ;
      irq_id <= id_n;
      irq_adr <= VEC_BASE + (32'(id_n) << 2);
      ack_err <= irq_ack && !ack_ok;
    end
  end
endmodule

// File: tb/tb_irq_ctrl_vec.sv
// tb_irq_ctrl_vec: directed scoreboard bench for irq_ctrl_vec
module tb_irq_ctrl_vec;
  logic clk = 1'b0;
  logic res;
  logic [31:0] irq_src, mask_wdata, mask, pending, irq_adr;
  logic mask_we, irq_ack, irq_ret, irq, ack_err, irq_q;
  logic [4:0] irq_ack_id, irq_id;
  logic [2:0] nest_lvl;
  int checks = 0;
  int errors = 0;
  typedef struct packed {logic err; logic [4:0] id; logic [31:0] adr;} ev_t;
  ev_t q[$];
  irq_ctrl_vec dut (
    .clk(clk), .res(res), .irq_src(irq_src), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .irq_ack(irq_ack), .irq_ack_id(irq_ack_id), .irq_ret(irq_ret), .irq(irq), .irq_id(irq_id),
    .irq_adr(irq_adr), .mask(mask), .pending(pending), .nest_lvl(nest_lvl), .ack_err(ack_err)
  );
  always #5 clk = ~clk;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse(int i);
    irq_src[i] = 1'b1;
    cyc(1);
    irq_src[i] = 1'b0;
  endtask
  task automatic set_mask(logic [31:0] v);
    mask_we = 1'b1;
    mask_wdata = v;
    cyc(1);
    mask_we = 1'b0;
  endtask
  task automatic ack(logic [4:0] id);
    irq_ack = 1'b1;
    irq_ack_id = id;
    cyc(1);
    irq_ack = 1'b0;
  endtask
  task automatic ret();
    irq_ret = 1'b1;
    cyc(1);
    irq_ret = 1'b0;
  endtask
  task automatic exp_req(logic [4:0] id, logic [31:0] adr);
    q.push_back({1'b0, id, adr});
  endtask
  task automatic wait_irq(string n);
    int t = 0;
    while (!irq && t < 20) begin
      cyc(1);
      t++;
    end
    chk({n, " irq timeout"}, 32'(irq), 32'd1);
  endtask
  task automatic got(logic err);
    ev_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected event err=%0b id=%0d adr=%h", err, irq_id, irq_adr);
    end else begin
      e = q.pop_front();
      chk("ev kind", 32'(err), 32'(e.err));
      chk("ev irq_id", 32'(irq_id), 32'(e.id));
      chk("ev irq_adr", irq_adr, e.adr);
    end
  endtask
  initial begin
    irq_q = 1'b0;
    forever begin
      @(negedge clk);
      if (res) begin
        if (irq && !irq_q) got(1'b0);
        if (ack_err) got(1'b1);
      end
      irq_q = irq;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int ids[4] = '{8, 6, 4, 2};
    logic [31:0] adrs[4] = '{32'h1C00_8020, 32'h1C00_8018, 32'h1C00_8010, 32'h1C00_8008};
    res = 1'b0;
    irq_src = '0;
    mask_we = 1'b0;
    mask_wdata = '0;
    irq_ack = 1'b0;
    irq_ack_id = '0;
    irq_ret = 1'b0;
    cyc(2);
    chk("rst irq", 32'(irq), 32'd0);
    chk("rst irq_id", 32'(irq_id), 32'd0);
    chk("rst irq_adr", irq_adr, 32'h1C00_8000);
    chk("rst mask", mask, 32'd0);
    chk("rst pending", pending, 32'd0);
    chk("rst nest_lvl", 32'(nest_lvl), 32'd0);
    chk("rst ack_err", 32'(ack_err), 32'd0);
    res = 1'b1;
    cyc(1);
    set_mask(32'h0000_0001);
    exp_req(5'd0, 32'h1C00_8000);
    pulse(0);
    chk("t1 pending set", 32'(pending[0]), 32'd1);
    chk("t1 irq not yet", 32'(irq), 32'd0);
    cyc(1);
    chk("t1 irq latency", 32'(irq), 32'd1);
    ack(5'd0);
    chk("t1 pending clr", 32'(pending[0]), 32'd0);
    chk("t1 nest", 32'(nest_lvl), 32'd1);
    chk("t1 irq drop", 32'(irq), 32'd0);
    ret();
    chk("t1 nest ret", 32'(nest_lvl), 32'd0);
    ret();
    chk("empty ret", 32'(nest_lvl), 32'd0);
    set_mask(32'hFFFF_FFFF);
    exp_req(5'd3, 32'h1C00_800C);
    irq_src[7] = 1'b1;
    irq_src[3] = 1'b1;
    cyc(1);
    irq_src = '0;
    wait_irq("t2 first");
    ack(5'd3);
    cyc(5);
    chk("t2 no 7 while 3 active", 32'(irq), 32'd0);
    chk("t2 pending7", 32'(pending[7]), 32'd1);
    exp_req(5'd7, 32'h1C00_801C);
    ret();
    wait_irq("t2 second");
    ack(5'd7);
    ret();
    exp_req(5'd5, 32'h1C00_8014);
    pulse(5);
    wait_irq("t3 five");
    ack(5'd5);
`ifdef IRQ_NEST_EN
    exp_req(5'd2, 32'h1C00_8008);
    pulse(2);
    wait_irq("t3 preempt");
    ack(5'd2);
    chk("t3 nest2", 32'(nest_lvl), 32'd2);
    ret();
    ret();
`else
    pulse(2);
    cyc(5);
    chk("t3 blocked", 32'(irq), 32'd0);
    chk("t3 nest1", 32'(nest_lvl), 32'd1);
    exp_req(5'd2, 32'h1C00_8008);
    ret();
    wait_irq("t3 after ret");
    ack(5'd2);
    ret();
`endif
    chk("t3 nest0", 32'(nest_lvl), 32'd0);
    exp_req(5'd4, 32'h1C00_8010);
    pulse(4);
    wait_irq("t4");
    set_mask(~32'h0000_0010);
    chk("t4 irq held", 32'(irq), 32'd1);
    cyc(1);
    chk("t4 irq dropped", 32'(irq), 32'd0);
    chk("t4 pending4", 32'(pending[4]), 32'd1);
    exp_req(5'd4, 32'h1C00_8010);
    set_mask(32'hFFFF_FFFF);
    wait_irq("t4 reissue");
    ack(5'd4);
    ret();
    exp_req(5'd6, 32'h1C00_8018);
    pulse(6);
    wait_irq("t5");
    q.push_back({1'b1, 5'd6, 32'h1C00_8018});
    ack(5'd9);
    chk("t5 ack_err", 32'(ack_err), 32'd1);
    chk("t5 irq stays", 32'(irq), 32'd1);
    chk("t5 pending6", 32'(pending[6]), 32'd1);
    cyc(1);
    chk("t5 ack_err pulse", 32'(ack_err), 32'd0);
    ack(5'd6);
    ret();
    exp_req(5'd1, 32'h1C00_8004);
    pulse(1);
    wait_irq("t6");
    irq_src[1] = 1'b1;
    ack(5'd1);
    irq_src[1] = 1'b0;
    chk("t6 edge wins", 32'(pending[1]), 32'd1);
    chk("t6 nest", 32'(nest_lvl), 32'd1);
    exp_req(5'd1, 32'h1C00_8004);
    ret();
    wait_irq("t6 again");
    ack(5'd1);
    ret();
`ifdef IRQ_NEST_EN
    for (int i = 0; i < 4; i++) begin
      exp_req(5'(ids[i]), adrs[i]);
      pulse(ids[i]);
      wait_irq("t7 fill");
      ack(5'(ids[i]));
    end
    chk("t7 full", 32'(nest_lvl), 32'd4);
    pulse(0);
    cyc(5);
    chk("t7 full no irq", 32'(irq), 32'd0);
    chk("t7 pending0", 32'(pending[0]), 32'd1);
    exp_req(5'd0, 32'h1C00_8000);
    ret();
    wait_irq("t7 after ret");
    ack(5'd0);
    chk("t7 nest4", 32'(nest_lvl), 32'd4);
    repeat (4) ret();
`else
    exp_req(5'd8, adrs[0]);
    pulse(8);
    wait_irq("t7 eight");
    ack(5'd8);
    pulse(6);
    cyc(5);
    chk("t7 single active", 32'(irq), 32'd0);
    chk("t7 nest1", 32'(nest_lvl), 32'd1);
    exp_req(5'd6, adrs[1]);
    ret();
    wait_irq("t7 after ret");
    ack(5'd6);
    ret();
`endif
    chk("t7 nest0", 32'(nest_lvl), 32'd0);
    cyc(3);
    chk("scoreboard drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
